// File: rtl/aes_round_sched.sv
// Key-schedule / round sequencer for an iterative AES datapath.
// Optional handshake counter port blk_cnt is built when AES_SCHED_CNT_EN is defined.
module aes_round_sched #(
  parameter int NROUNDS = 14,
  parameter int KEY_W   = 128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_req,
  input  logic             key_sel,
  output logic             key_ack,
  output logic             d_tk,
  input  logic             ks_load,
  input  logic [3:0]       ks_round,
  input  logic [KEY_W-1:0] ks_out,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [3:0]       dp_round_num,
  output logic             dp_final,
  output logic [KEY_W-1:0] dp_key,
  output logic             out_valid,
  input  logic             out_ready
`ifdef AES_SCHED_CNT_EN
  , output logic [15:0]    blk_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FLIP = 3'd1,
    KEXP = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  state_t           state_r, state_s;
  logic             d_tk_r, d_tk_s;
  logic             keys_valid_r, keys_valid_s;
  logic             cur_sel_r, cur_sel_s;
  logic             kstart_r, kstart_s;
  logic             key_ack_r, key_ack_s;
  logic [3:0]       rnd_r, rnd_s;
  logic             dp_load_r, dp_load_s;
  logic             dp_round_en_r, dp_round_en_s;
  logic [3:0]       dp_round_num_r, dp_round_num_s;
  logic             dp_final_r, dp_final_s;
  logic [KEY_W-1:0] dp_key_r, dp_key_s;
  logic             out_valid_r, out_valid_s;
  logic             accept_s, capture_s;
  logic [KEY_W-1:0] rk_r [0:NROUNDS];

  assign blk_ready = (state_r == IDLE) & keys_valid_r & ~key_req;
  assign accept_s  = blk_valid & blk_ready;
  // A stream only counts once it has restarted at round 0 inside KEXP.
  assign capture_s = (state_r == KEXP) & ks_load & (ks_round <= LAST_RND) &
                     (kstart_r | (ks_round == 4'd0));

  // Next-state and next-output decode.
  always_comb begin
    state_s        = state_r;
    d_tk_s         = d_tk_r;
    keys_valid_s   = keys_valid_r;
    cur_sel_s      = cur_sel_r;
    kstart_s       = kstart_r;
    key_ack_s      = 1'b0;
    rnd_s          = rnd_r;
    dp_load_s      = 1'b0;
    dp_round_en_s  = 1'b0;
    dp_round_num_s = 4'd0;
    dp_final_s     = 1'b0;
    dp_key_s       = {KEY_W{1'b0}};
    out_valid_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_req) begin
          if (keys_valid_r && (key_sel == cur_sel_r)) begin
            key_ack_s = 1'b1;
          end else if (key_sel != d_tk_r) begin
            d_tk_s       = ~d_tk_r;
            keys_valid_s = 1'b0;
            cur_sel_s    = key_sel;
            kstart_s     = 1'b0;
            state_s      = KEXP;
          end else begin
            // Same level requested: toggle away now, toggle back in FLIP.
            d_tk_s       = ~d_tk_r;
            keys_valid_s = 1'b0;
            cur_sel_s    = key_sel;
            state_s      = FLIP;
          end
        end else if (accept_s) begin
          dp_load_s = 1'b1;
          dp_key_s  = rk_r[0];
          rnd_s     = 4'd1;
          state_s   = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      FLIP: begin
        if (ks_load) begin
          d_tk_s   = ~d_tk_r;
          kstart_s = 1'b0;
          state_s  = KEXP;
        end else begin
          state_s = FLIP;
        end
      end
      KEXP: begin
        if (capture_s && (ks_round == LAST_RND)) begin
          keys_valid_s = 1'b1;
          key_ack_s    = 1'b1;
          kstart_s     = 1'b0;
          state_s      = IDLE;
        end else if (capture_s) begin
          kstart_s = 1'b1;
        end else begin
          kstart_s = kstart_r;
        end
      end
      RUN: begin
        dp_round_en_s  = 1'b1;
        dp_round_num_s = rnd_r;
        dp_key_s       = rk_r[rnd_r];
        if (rnd_r == LAST_RND) begin
          dp_final_s = 1'b1;
          state_s    = DONE;
        end else begin
          rnd_s = rnd_r + 4'd1;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_s = IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      d_tk_r         <= 1'b0;
      keys_valid_r   <= 1'b0;
      cur_sel_r      <= 1'b0;
      kstart_r       <= 1'b0;
      key_ack_r      <= 1'b0;
      rnd_r          <= 4'd0;
      dp_load_r      <= 1'b0;
      dp_round_en_r  <= 1'b0;
      dp_round_num_r <= 4'd0;
      dp_final_r     <= 1'b0;
      dp_key_r       <= {KEY_W{1'b0}};
      out_valid_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      d_tk_r         <= d_tk_s;
      keys_valid_r   <= keys_valid_s;
      cur_sel_r      <= cur_sel_s;
      kstart_r       <= kstart_s;
      key_ack_r      <= key_ack_s;
      rnd_r          <= rnd_s;
      dp_load_r      <= dp_load_s;
      dp_round_en_r  <= dp_round_en_s;
      dp_round_num_r <= dp_round_num_s;
      dp_final_r     <= dp_final_s;
      dp_key_r       <= dp_key_s;
      out_valid_r    <= out_valid_s;
    end
  end

  // Round-key buffer; contents are meaningless until keys_valid.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      rk_r[ks_round] <= ks_out;
    end
  end

`ifdef AES_SCHED_CNT_EN
  logic [15:0] blk_cnt_r;

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blk_cnt_r <= 16'd0;
    end else if (out_valid_r && out_ready && (blk_cnt_r != 16'hFFFF)) begin
      blk_cnt_r <= blk_cnt_r + 16'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  assign blk_cnt = blk_cnt_r;
`endif

  assign key_ack      = key_ack_r;
  assign d_tk         = d_tk_r;
  assign dp_load      = dp_load_r;
  assign dp_round_en  = dp_round_en_r;
  assign dp_round_num = dp_round_num_r;
  assign dp_final     = dp_final_r;
  assign dp_key       = dp_key_r;
  assign out_valid    = out_valid_r;

endmodule
